// File: rtl/signed_or_unsigned_div.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned operands, valid/ready on both sides.
// Build option: define SIGNED_OR_UNSIGNED_DIV_FAST_DBZ_EN so a zero divisor skips CALC/FIX and goes straight to DONE.
module signed_or_unsigned_div #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         sign,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] quo,
  output logic [n-1:0] rem,
  output logic         div_by_zero
);

  localparam int CW = $clog2(n + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [n-1:0]  prem_q, prem_d;
  logic [n-1:0]  dvd_q, dvd_d;
  logic [n-1:0]  dvs_q, dvs_d;
  logic [n-1:0]  a_raw_q, a_raw_d;
  logic          neg_q_q, neg_q_d;
  logic          neg_r_q, neg_r_d;
  logic          dbz_q, dbz_d;
  logic [n-1:0]  quo_q, quo_d;
  logic [n-1:0]  rem_q, rem_d;
  logic          div_by_zero_q, div_by_zero_d;

  logic [n-1:0] a_abs_w, b_abs_w;
  logic         b_zero_w;
  logic [n:0]   shifted_w;
  logic         fits_w;

  assign a_abs_w  = (sign && a[n-1]) ? -a : a;
  assign b_abs_w  = (sign && b[n-1]) ? -b : b;
  assign b_zero_w = (b == '0);

  // The shifted partial remainder is n+1 bits wide; when the divisor fits,
  // the difference is below the divisor and so fits back into n bits.
  assign shifted_w = {prem_q, dvd_q[n-1]};
  assign fits_w    = (shifted_w >= {1'b0, dvs_q});

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    prem_d        = prem_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    a_raw_d       = a_raw_q;
    neg_q_d       = neg_q_q;
    neg_r_d       = neg_r_q;
    dbz_d         = dbz_q;
    quo_d         = quo_q;
    rem_d         = rem_q;
    div_by_zero_d = div_by_zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          neg_q_d = sign & (a[n-1] ^ b[n-1]);
          neg_r_d = sign & a[n-1];
          a_raw_d = a;
          dbz_d   = b_zero_w;
          dvd_d   = a_abs_w;
          dvs_d   = b_abs_w;
          prem_d  = '0;
          cnt_d   = CW'(n);
          state_d = CALC;
`ifdef SIGNED_OR_UNSIGNED_DIV_FAST_DBZ_EN
          if (b_zero_w) begin
            quo_d         = '1;
            rem_d         = a;
            div_by_zero_d = 1'b1;
            state_d       = DONE;
          end
`endif
        end
      end
      CALC: begin
        prem_d = fits_w ? (shifted_w[n-1:0] - dvs_q) : shifted_w[n-1:0];
        dvd_d  = {dvd_q[n-2:0], fits_w};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        // A zero divisor reports the raw dividend, bypassing the sign fix-up.
        if (dbz_q) begin
          quo_d         = '1;
          rem_d         = a_raw_q;
          div_by_zero_d = 1'b1;
        end else begin
          quo_d         = neg_q_q ? -dvd_q : dvd_q;
          rem_d         = neg_r_q ? -prem_q : prem_q;
          div_by_zero_d = 1'b0;
        end
        state_d = DONE;
      end
      default: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      prem_q        <= '0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      a_raw_q       <= '0;
      neg_q_q       <= 1'b0;
      neg_r_q       <= 1'b0;
      dbz_q         <= 1'b0;
      quo_q         <= '0;
      rem_q         <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prem_q        <= prem_d;
      dvd_q         <= dvd_d;
      dvs_q         <= dvs_d;
      a_raw_q       <= a_raw_d;
      neg_q_q       <= neg_q_d;
      neg_r_q       <= neg_r_d;
      dbz_q         <= dbz_d;
      quo_q         <= quo_d;
      rem_q         <= rem_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quo         = quo_q;
  assign rem         = rem_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_signed_or_unsigned_div.sv
// Scoreboard bench for signed_or_unsigned_div at n=4: directed cases, backpressure, mid-operation reset, exhaustive sweep.
module tb_signed_or_unsigned_div;
  localparam int N   = 4;
  localparam int TMO = 50;
  // Latencies are counted in rising edges after the accept edge.
  localparam int LAT = N + 1;
`ifdef SIGNED_OR_UNSIGNED_DIV_FAST_DBZ_EN
  localparam int DBZ_LAT = 0;
`else
  localparam int DBZ_LAT = N + 1;
`endif

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         sign = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] quo;
  logic [N-1:0] rem;
  logic         div_by_zero;

  res_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  signed_or_unsigned_div #(.n(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sign(sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .quo(quo), .rem(rem), .div_by_zero(div_by_zero)
  );

  function automatic res_t mk(input logic [N-1:0] q, input logic [N-1:0] r, input logic z);
    res_t e;
    e.q = q; e.r = r; e.z = z;
    return e;
  endfunction

  // Reference model on 32-bit ints: SV int / and % truncate toward zero.
  function automatic res_t model(input logic [N-1:0] av, input logic [N-1:0] bv, input logic s);
    int sa, sbv, qi, ri;
    if (bv == '0) return mk('1, av, 1'b1);
    sa  = s ? int'($signed(av)) : int'(av);
    sbv = s ? int'($signed(bv)) : int'(bv);
    qi  = sa / sbv;
    ri  = sa % sbv;
    return mk(qi[N-1:0], ri[N-1:0], 1'b0);
  endfunction

  // Drives one request and returns at the falling edge right after its accept edge.
  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv, input logic s, input res_t exp);
    int w;
    sb_q.push_back(exp);
    @(negedge clk);
    a = av; b = bv; sign = s; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < TMO) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = N'($urandom); b = N'($urandom); sign = 1'($urandom);
  endtask

  // Waits (bounded) for out_valid, samples the result, then completes the handshake.
  task automatic collect(output res_t got, output int lat, output bit ok);
    lat = 0;
    while (!out_valid && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    ok  = out_valid;
    got = {quo, rem, div_by_zero};
    $display("txn: quo=%0d rem=%0d dbz=%0b latency=%0d", quo, rem, div_by_zero, lat);
    if (ok) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, quo, rem, div_by_zero} !== {1'b1, 1'b0, {N{1'b0}}, {N{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b vld=%0b q=%0d r=%0d z=%0b, required rdy=1 vld=0 q=0 r=0 z=0",
               in_ready, out_valid, quo, rem, div_by_zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_directed(input string name, input logic [N-1:0] av, input logic [N-1:0] bv,
                              input logic s, input res_t exp, input int exp_lat);
    res_t got, want;
    int   lat;
    bit   ok;
    issue(av, bv, s, exp);
    collect(got, lat, ok);
    want = sb_q.pop_front();
    checks++;
    if (!ok || got !== want) begin
      errors++;
      $display("FAIL %s: got q=%b r=%b z=%b valid=%0b, required q=%b r=%b z=%b",
               name, got.q, got.r, got.z, ok, want.q, want.r, want.z);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d, required %0d", name, lat, exp_lat);
    end
  endtask

  task automatic test_unsigned;
    run_directed("unsigned_13_3", 4'd13, 4'd3, 1'b0, mk(4'd4, 4'd1, 1'b0), LAT);
    run_directed("unsigned_15_4", 4'd15, 4'd4, 1'b0, mk(4'd3, 4'd3, 1'b0), LAT);
  endtask

  task automatic test_signed;
    run_directed("signed_m7_2", 4'b1001, 4'd2, 1'b1, mk(4'b1101, 4'b1111, 1'b0), LAT);
    run_directed("signed_7_m2", 4'd7, 4'b1110, 1'b1, mk(4'b1101, 4'd1, 1'b0), LAT);
  endtask

  task automatic test_overflow_and_zero;
    run_directed("signed_overflow", 4'b1000, 4'b1111, 1'b1, mk(4'b1000, 4'd0, 1'b0), LAT);
    run_directed("div_zero_unsigned", 4'd9, 4'd0, 1'b0, mk(4'b1111, 4'd9, 1'b1), DBZ_LAT);
    run_directed("div_zero_signed", 4'd9, 4'd0, 1'b1, mk(4'b1111, 4'd9, 1'b1), DBZ_LAT);
  endtask

  task automatic test_backpressure;
    res_t want;
    int   w;
    issue(4'd11, 4'd2, 1'b0, mk(4'd5, 4'd1, 1'b0));
    want = sb_q.pop_front();
    w = 0;
    while (!out_valid && w < TMO) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({out_valid, in_ready, quo, rem} !== {1'b1, 1'b0, want.q, want.r}) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: vld=%0b rdy=%0b q=%0d r=%0d, required vld=1 rdy=0 q=%0d r=%0d",
                 i, out_valid, in_ready, quo, rem, want.q, want.r);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL backpressure_release: rdy=%0b vld=%0b, required rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_midop;
    issue(4'd13, 4'd3, 1'b0, mk(4'd4, 4'd1, 1'b0));
    @(negedge clk);
    rst_n = 1'b0;
    void'(sb_q.pop_back());
    #1;
    checks++;
    if ({in_ready, out_valid, quo, rem, div_by_zero} !== {1'b1, 1'b0, {N{1'b0}}, {N{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset_midop: rdy=%0b vld=%0b q=%0d r=%0d z=%0b, required rdy=1 vld=0 q=0 r=0 z=0",
               in_ready, out_valid, quo, rem, div_by_zero);
    end
    repeat (N + 3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop_no_result: vld=%0b, required 0", out_valid);
    end
    rst_n = 1'b1;
    run_directed("after_reset_6_4", 4'd6, 4'd4, 1'b0, mk(4'd1, 4'd2, 1'b0), LAT);
  endtask

  task automatic test_exhaustive;
    res_t got, want;
    int   lat;
    bit   ok;
    for (int s = 0; s < 2; s++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          issue(N'(ai), N'(bi), 1'(s), model(N'(ai), N'(bi), 1'(s)));
          collect(got, lat, ok);
          want = sb_q.pop_front();
          checks++;
          if (!ok || got !== want || lat !== ((bi == 0) ? DBZ_LAT : LAT)) begin
            errors++;
            $display("FAIL exhaustive s=%0d a=%0d b=%0d: got q=%b r=%b z=%b lat=%0d, required q=%b r=%b z=%b",
                     s, ai, bi, got.q, got.r, got.z, lat, want.q, want.r, want.z);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow_and_zero();
    test_backpressure();
    test_reset_midop();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
